// File: rtl/histogram_lut_uygulayici_if.sv
`default_nettype none
// ============================================================================
// Module      : histogram_lut_uygulayici_if
// Description : Bundles the LUT-load port and the pixel stream port of the
//               histogram LUT remapper.
//               master : drives LUT entries and input pixels, receives the
//                        remapped pixels and status.
//               slave  : the remapper itself.
//   lut_gecerli_i / lut_veri_i   LUT entry strobe and value (entries 0..N-1)
//   lut_hazir_o / lut_hata_o     write bank not full / sticky overflow flag
//   etkin_i / pixel_i / hazir_o  input pixel valid / value / accept enable
//   pixel_o / gecerli_o          remapped pixel and its valid
//   cerceve_bitti_o              pulse with the valid of a frame's last pixel
// Revision    : 1.0 - initial release
// ============================================================================
interface histogram_lut_uygulayici_if #(
    parameter int PIXEL_BIT = 8
);
    logic                 lut_gecerli_i;
    logic [PIXEL_BIT-1:0] lut_veri_i;
    logic                 lut_hazir_o;
    logic                 lut_hata_o;
    logic                 etkin_i;
    logic [PIXEL_BIT-1:0] pixel_i;
    logic                 hazir_o;
    logic [PIXEL_BIT-1:0] pixel_o;
    logic                 gecerli_o;
    logic                 cerceve_bitti_o;

    modport master (
        output lut_gecerli_i, lut_veri_i, etkin_i, pixel_i,
        input  lut_hazir_o, lut_hata_o, hazir_o, pixel_o, gecerli_o, cerceve_bitti_o
    );

    modport slave (
        input  lut_gecerli_i, lut_veri_i, etkin_i, pixel_i,
        output lut_hazir_o, lut_hata_o, hazir_o, pixel_o, gecerli_o, cerceve_bitti_o
    );
endinterface
`default_nettype wire

// File: rtl/histogram_lut_uygulayici.sv
`default_nettype none
// ============================================================================
// Module      : histogram_lut_uygulayici
// Description : Final stage of histogram equalisation. Captures the streamed
//               2**PIXEL_BIT-entry LUT into a ping-pong bank pair and maps a
//               raster pixel stream through the active bank (out = LUT[in]).
//               A freshly loaded bank becomes active only between frames.
// Ports       : clk_i  - single clock, rising edge
//               rst_i  - synchronous reset, active-high
//               bus    - histogram_lut_uygulayici_if.slave (LUT load port,
//                        pixel in/out stream, status)
// Revision    : 1.0 - initial release
// ============================================================================
module histogram_lut_uygulayici #(
    parameter int PIXEL_BIT = 8,
    parameter int GENISLIK  = 320,
    parameter int YUKSEKLIK = 240
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    histogram_lut_uygulayici_if.slave    bus
);

    localparam int DERINLIK      = 2 ** PIXEL_BIT;
    localparam int PIKSEL_SAYISI = GENISLIK * YUKSEKLIK;
    localparam int SAYAC_W       = (PIKSEL_SAYISI > 1) ? $clog2(PIKSEL_SAYISI) : 1;
    localparam logic [SAYAC_W-1:0]   SON_PIKSEL = SAYAC_W'(PIKSEL_SAYISI - 1);
    localparam logic [PIXEL_BIT-1:0] SON_GIRIS  = PIXEL_BIT'(DERINLIK - 1);

    // Both banks share one RAM; the MSB of the address selects the bank.
    logic [PIXEL_BIT-1:0] lut_ram [0:2*DERINLIK-1];

    logic                 yazma_bank_q,     yazma_bank_d;
    logic                 yazma_dolu_q,     yazma_dolu_d;
    logic                 okuma_gecerli_q,  okuma_gecerli_d;
    logic [PIXEL_BIT-1:0] lut_sayac_q,      lut_sayac_d;
    logic                 lut_hata_q,       lut_hata_d;
    logic [SAYAC_W-1:0]   piksel_sayac_q,   piksel_sayac_d;
    logic                 cerceve_ortasi_q, cerceve_ortasi_d;
    logic                 gecerli_q,        gecerli_d;
    logic                 cerceve_bitti_q,  cerceve_bitti_d;
    logic [PIXEL_BIT-1:0] pixel_q;

    logic                 lut_yaz;
    logic                 degistir;
    logic                 hazir;
    logic                 kabul;
    logic [PIXEL_BIT:0]   yazma_adres;
    logic [PIXEL_BIT:0]   okuma_adres;

    // A full write bank is promoted only while no frame is in flight; during
    // that cycle pixel acceptance is blocked so no read straddles the swap.
    assign lut_yaz     = bus.lut_gecerli_i & ~yazma_dolu_q & ~rst_i;
    assign degistir    = yazma_dolu_q & ~cerceve_ortasi_q;
    assign hazir       = okuma_gecerli_q & ~degistir;
    assign kabul       = bus.etkin_i & hazir;
    // The read bank is always the one not being written.
    assign yazma_adres = {yazma_bank_q, lut_sayac_q};
    assign okuma_adres = {~yazma_bank_q, bus.pixel_i};

    always_comb begin
        yazma_bank_d     = yazma_bank_q;
        yazma_dolu_d     = yazma_dolu_q;
        okuma_gecerli_d  = okuma_gecerli_q;
        lut_sayac_d      = lut_sayac_q;
        lut_hata_d       = lut_hata_q;
        piksel_sayac_d   = piksel_sayac_q;
        cerceve_ortasi_d = cerceve_ortasi_q;
        gecerli_d        = kabul;
        cerceve_bitti_d  = 1'b0;

        // LUT loading; the counter wraps so the next load starts at entry 0.
        if (lut_yaz) begin
            lut_sayac_d = lut_sayac_q + 1'b1;
            if (lut_sayac_q == SON_GIRIS) begin
                yazma_dolu_d = 1'b1;
            end
        end
        if (bus.lut_gecerli_i && yazma_dolu_q) begin
            lut_hata_d = 1'b1;
        end

        if (degistir) begin
            yazma_bank_d    = ~yazma_bank_q;
            okuma_gecerli_d = 1'b1;
            yazma_dolu_d    = 1'b0;
        end

        // Frame position advances only on accepted pixels.
        if (kabul) begin
            if (piksel_sayac_q == SON_PIKSEL) begin
                piksel_sayac_d   = '0;
                cerceve_ortasi_d = 1'b0;
                cerceve_bitti_d  = 1'b1;
            end else begin
                piksel_sayac_d   = piksel_sayac_q + 1'b1;
                cerceve_ortasi_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            yazma_bank_q     <= 1'b0;
            yazma_dolu_q     <= 1'b0;
            okuma_gecerli_q  <= 1'b0;
            lut_sayac_q      <= '0;
            lut_hata_q       <= 1'b0;
            piksel_sayac_q   <= '0;
            cerceve_ortasi_q <= 1'b0;
            gecerli_q        <= 1'b0;
            cerceve_bitti_q  <= 1'b0;
        end else begin
            yazma_bank_q     <= yazma_bank_d;
            yazma_dolu_q     <= yazma_dolu_d;
            okuma_gecerli_q  <= okuma_gecerli_d;
            lut_sayac_q      <= lut_sayac_d;
            lut_hata_q       <= lut_hata_d;
            piksel_sayac_q   <= piksel_sayac_d;
            cerceve_ortasi_q <= cerceve_ortasi_d;
            gecerli_q        <= gecerli_d;
            cerceve_bitti_q  <= cerceve_bitti_d;
        end
    end

    // LUT storage is deliberately not reset; validity is tracked by the flags.
    always_ff @(posedge clk_i) begin
        if (lut_yaz) begin
            lut_ram[yazma_adres] <= bus.lut_veri_i;
        end
    end

    // Synchronous read register; holds its value between accepted pixels.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pixel_q <= '0;
        end else if (kabul) begin
            pixel_q <= lut_ram[okuma_adres];
        end
    end

    assign bus.lut_hazir_o     = ~yazma_dolu_q;
    assign bus.lut_hata_o      = lut_hata_q;
    assign bus.hazir_o         = hazir;
    assign bus.pixel_o         = pixel_q;
    assign bus.gecerli_o       = gecerli_q;
    assign bus.cerceve_bitti_o = cerceve_bitti_q;

endmodule
`default_nettype wire
